// File: rtl/rd_wait_target.sv
// Read target: takes the sequencer's rd strobe, issues one memory read, drives ws, queues data on ds.
// Latency: rd in cycle 0, ws low from cycle 1+wait_cfg, ds in the following cycle, out_valid one cycle later.
// Backpressure: ws stays high while the output FIFO is full; out_valid/out_ready pops the FIFO head.
// Optional build macro RD_WAIT_TARGET_ERR_EN adds a sticky protocol-error output err.
module rd_wait_target #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int WCW        = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd,
  input  logic                          ds,
  input  logic [AW-1:0]                 addr,
  input  logic [WCW-1:0]                wait_cfg,
  output logic                          ws,
  output logic                          mem_en,
  output logic [AW-1:0]                 mem_addr,
  input  logic [DW-1:0]                 mem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DW-1:0]                 out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
`ifdef RD_WAIT_TARGET_ERR_EN
  ,
  output logic                          err
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_WAIT = 2'd1,
    T_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WCW-1:0]  cnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            cap_q;
  logic            push;
  logic            pop;
  logic            fifo_full;

  // Output FIFO storage and pointers
  logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [DW-1:0]   last_q;

  assign fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign out_valid = (fifo_cnt != '0);
  // When empty, present the last popped word so out_data stays stable.
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : last_q;
  // Accepting cycle drives the live address; afterwards the registered copy.
  assign mem_addr  = mem_en ? addr : addr_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= T_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode; rd during T_WAIT/T_HOLD never starts a new read
  always_comb begin
    state_d = state_q;
    ws      = 1'b0;
    mem_en  = 1'b0;
    push    = 1'b0;
    case (state_q)
      T_IDLE: begin
        if (rd) begin
          mem_en  = 1'b1;
          state_d = T_WAIT;
        end
      end
      T_WAIT: begin
        ws = (cnt_q != '0) || fifo_full;
        if (!ws) state_d = T_HOLD;
      end
      T_HOLD: begin
        if (ds) begin
          push    = 1'b1;
          state_d = T_IDLE;
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

  // Transaction datapath: latch addr/wait count on accept, grab memory data exactly once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      cap_q  <= 1'b0;
    end else begin
      if (mem_en) begin
        addr_q <= addr;
        cnt_q  <= wait_cfg;
        cap_q  <= 1'b1;
      end else begin
        if (state_q == T_WAIT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        if (cap_q) begin
          data_q <= mem_rdata;
          cap_q  <= 1'b0;
        end
      end
    end
  end

  // FIFO storage write; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_q;
  end

  // FIFO pointers, occupancy and last-popped word; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      last_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef RD_WAIT_TARGET_ERR_EN
  // Sticky protocol error: ds outside T_HOLD or rd while in T_HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((ds && state_q != T_HOLD) || (rd && state_q == T_HOLD)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rd_wait_target.sv
// Bench for rd_wait_target: drives the sequencer side, models a 1-cycle memory,
// and scoreboards every word leaving the output FIFO.
`timescale 1ns/1ps
module tb_rd_wait_target;
  localparam int AW = 8, DW = 16, WCW = 4, FD = 2, CW = $clog2(FD) + 1;

  logic clk = 1'b0, rst_n = 1'b1, rd = 1'b0, ds = 1'b0, out_ready = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [WCW-1:0] wait_cfg = '0;
  logic [DW-1:0]  mem_rdata = '0;
  logic           ws, mem_en, out_valid;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  fifo_cnt;
`ifdef RD_WAIT_TARGET_ERR_EN
  logic           err;
`endif

  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_word;
  int n_checks = 0, n_pass = 0, en_cnt = 0;

  always #5 clk = ~clk;

  rd_wait_target #(.AW(AW), .DW(DW), .WCW(WCW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .rd(rd), .ds(ds), .addr(addr), .wait_cfg(wait_cfg),
    .ws(ws), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .fifo_cnt(fifo_cnt)
`ifdef RD_WAIT_TARGET_ERR_EN
    , .err(err)
`endif
  );

  // Synchronous memory: data valid one cycle after mem_en, junk otherwise
  always @(posedge clk) mem_rdata <= mem_en ? mem_arr[mem_addr] : 16'hDEAD;

  // Monitor: count read pulses and check popped words against the scoreboard
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (mem_en) en_cnt++;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL pop_unexpected: out_data=%h, required no output", out_data);
        end else begin
          exp_word = sb.pop_front();
          if (out_data !== exp_word) $display("FAIL pop_data: out_data=%h required %h", out_data, exp_word);
          else n_pass++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sequencer driver for a whole read; ends at the negedge after the ds cycle
  task automatic fsm_read(input logic [AW-1:0] a, input logic [WCW-1:0] w, input logic hold,
                          output int ws_cycles, output bit timeout);
    @(negedge clk); rd = 1'b1; addr = a; wait_cfg = w; ds = 1'b0;
    ws_cycles = 0; timeout = 1'b0;
    @(negedge clk); rd = hold; #1;
    while (ws === 1'b1 && !timeout) begin
      ws_cycles++;
      if (ws_cycles > 100) timeout = 1'b1;
      else begin @(negedge clk); rd = hold; #1; end
    end
    @(negedge clk); rd = 1'b0;
    if (!timeout) begin ds = 1'b1; sb.push_back(mem_arr[a]); end
    @(negedge clk); ds = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (ws !== 1'b0) $display("FAIL rst_ws: ws=%b required 0", ws); else n_pass++;
    n_checks++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en: mem_en=%b required 0", mem_en); else n_pass++;
    n_checks++; if (mem_addr !== 8'h00) $display("FAIL rst_mem_addr: mem_addr=%h required 00", mem_addr); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: out_valid=%b required 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0000) $display("FAIL rst_out_data: out_data=%h required 0000", out_data); else n_pass++;
    n_checks++; if (fifo_cnt !== 2'd0) $display("FAIL rst_fifo_cnt: fifo_cnt=%0d required 0", fifo_cnt); else n_pass++;
`ifdef RD_WAIT_TARGET_ERR_EN
    n_checks++; if (err !== 1'b0) $display("FAIL rst_err: err=%b required 0", err); else n_pass++;
`endif
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int en0;
    out_ready = 1'b1; mem_arr[8'h10] = 16'hA5A5; en0 = en_cnt;
    @(negedge clk); rd = 1'b1; addr = 8'h10; wait_cfg = '0; #1;
    n_checks++; if (mem_en !== 1'b1) $display("FAIL basic_mem_en: mem_en=%b required 1", mem_en); else n_pass++;
    n_checks++; if (mem_addr !== 8'h10) $display("FAIL basic_mem_addr: mem_addr=%h required 10", mem_addr); else n_pass++;
    @(negedge clk); rd = 1'b0; #1;
    n_checks++; if (ws !== 1'b0) $display("FAIL basic_ws_c1: ws=%b required 0", ws); else n_pass++;
    @(negedge clk); ds = 1'b1; sb.push_back(16'hA5A5); #1;
    n_checks++; if (ws !== 1'b0) $display("FAIL basic_ws_c2: ws=%b required 0", ws); else n_pass++;
    @(negedge clk); ds = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid_c3: out_valid=%b required 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'hA5A5) $display("FAIL basic_data_c3: out_data=%h required a5a5", out_data); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (en_cnt - en0 !== 1) $display("FAIL basic_en_pulses: pulses=%0d required 1", en_cnt - en0); else n_pass++;
    n_checks++; if (fifo_cnt !== 2'd0) $display("FAIL basic_drain: fifo_cnt=%0d required 0", fifo_cnt); else n_pass++;
  endtask

  task automatic test_wait_states();
    int en0;
    out_ready = 1'b1; mem_arr[8'h40] = 16'h1234; en0 = en_cnt;
    @(negedge clk); rd = 1'b1; addr = 8'h40; wait_cfg = 4'd3; #1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); rd = 1'b1; addr = 8'h99; #1;
      n_checks++; if (ws !== 1'b1) $display("FAIL wait_ws_c%0d: ws=%b required 1", i, ws); else n_pass++;
      if (i == 2) begin
        n_checks++; if (mem_addr !== 8'h40) $display("FAIL wait_mem_addr: mem_addr=%h required 40", mem_addr); else n_pass++;
      end
    end
    @(negedge clk); rd = 1'b0; #1;
    n_checks++; if (ws !== 1'b0) $display("FAIL wait_ws_c4: ws=%b required 0", ws); else n_pass++;
    @(negedge clk); ds = 1'b1; sb.push_back(16'h1234);
    @(negedge clk); ds = 1'b0; #1;
    n_checks++; if (out_data !== 16'h1234) $display("FAIL wait_capture: out_data=%h required 1234", out_data); else n_pass++;
    n_checks++; if (en_cnt - en0 !== 1) $display("FAIL wait_en_pulses: pulses=%0d required 1", en_cnt - en0); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    int wsc; bit to;
    out_ready = 1'b0;
    mem_arr[8'h01] = 16'h0001; mem_arr[8'h02] = 16'h0002; mem_arr[8'h03] = 16'h0003;
    fsm_read(8'h01, 4'd0, 1'b0, wsc, to);
    fsm_read(8'h02, 4'd0, 1'b0, wsc, to);
    #1;
    n_checks++; if (fifo_cnt !== 2'd2) $display("FAIL bp_full: fifo_cnt=%0d required 2", fifo_cnt); else n_pass++;
    n_checks++; if (out_data !== 16'h0001) $display("FAIL bp_head: out_data=%h required 0001", out_data); else n_pass++;
    @(negedge clk); rd = 1'b1; addr = 8'h03; wait_cfg = '0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); rd = 1'b1; #1;
      n_checks++; if (ws !== 1'b1) $display("FAIL bp_ws_hold_c%0d: ws=%b required 1", i, ws); else n_pass++;
    end
    @(negedge clk); out_ready = 1'b1; #1;
    n_checks++; if (ws !== 1'b1) $display("FAIL bp_ws_pop_cycle: ws=%b required 1", ws); else n_pass++;
    @(negedge clk); rd = 1'b0; #1;
    n_checks++; if (ws !== 1'b0) $display("FAIL bp_ws_release: ws=%b required 0", ws); else n_pass++;
    @(negedge clk); ds = 1'b1; sb.push_back(16'h0003);
    @(negedge clk); ds = 1'b0; #1;
    for (int i = 0; i < 10 && fifo_cnt !== 2'd0; i++) begin @(negedge clk); #1; end
    n_checks++; if (fifo_cnt !== 2'd0 || sb.size() != 0)
      $display("FAIL bp_drain: fifo_cnt=%0d pending=%0d required 0/0", fifo_cnt, sb.size()); else n_pass++;
  endtask

  task automatic test_simul_push_pop();
    int wsc; bit to;
    out_ready = 1'b0; mem_arr[8'h20] = 16'h1111; mem_arr[8'h21] = 16'h2222;
    fsm_read(8'h20, 4'd0, 1'b0, wsc, to);
    rd = 1'b1; addr = 8'h21; wait_cfg = '0;
    @(negedge clk); rd = 1'b0; #1;
    n_checks++; if (ws !== 1'b0) $display("FAIL spp_ws: ws=%b required 0", ws); else n_pass++;
    @(negedge clk); ds = 1'b1; out_ready = 1'b1; sb.push_back(16'h2222); #1;
    n_checks++; if (fifo_cnt !== 2'd1) $display("FAIL spp_cnt_before: fifo_cnt=%0d required 1", fifo_cnt); else n_pass++;
    @(negedge clk); ds = 1'b0; out_ready = 1'b0; #1;
    n_checks++; if (fifo_cnt !== 2'd1) $display("FAIL spp_cnt_after: fifo_cnt=%0d required 1", fifo_cnt); else n_pass++;
    n_checks++; if (out_data !== 16'h2222) $display("FAIL spp_head: out_data=%h required 2222", out_data); else n_pass++;
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (fifo_cnt !== 2'd0) $display("FAIL spp_drain: fifo_cnt=%0d required 0", fifo_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int wsc; bit to;
    out_ready = 1'b0; mem_arr[8'h30] = 16'h3333; mem_arr[8'h32] = 16'hBEEF;
    fsm_read(8'h30, 4'd0, 1'b0, wsc, to);
    rd = 1'b1; addr = 8'h31; wait_cfg = 4'd5;
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b1; #1;
    n_checks++; if (ws !== 1'b1) $display("FAIL rmid_ws_before: ws=%b required 1", ws); else n_pass++;
    @(negedge clk); rd = 1'b0; rst_n = 1'b0; #1;
    sb.delete();
    n_checks++; if (ws !== 1'b0) $display("FAIL rmid_ws: ws=%b required 0", ws); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: out_valid=%b required 0", out_valid); else n_pass++;
    n_checks++; if (fifo_cnt !== 2'd0) $display("FAIL rmid_cnt: fifo_cnt=%0d required 0", fifo_cnt); else n_pass++;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    fsm_read(8'h32, 4'd1, 1'b1, wsc, to);
    #1;
    n_checks++; if (wsc !== 1 || to) $display("FAIL rmid_fresh_ws: ws_cycles=%0d timeout=%0d required 1/0", wsc, to); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF)
      $display("FAIL rmid_fresh_out: valid=%b data=%h required 1/beef", out_valid, out_data); else n_pass++;
    @(negedge clk); #1;
  endtask

  task automatic test_stray_ds();
    int wsc; bit to;
    out_ready = 1'b1; mem_arr[8'h50] = 16'h5A5A;
`ifdef RD_WAIT_TARGET_ERR_EN
    n_checks++; if (err !== 1'b0) $display("FAIL err_clean: err=%b required 0", err); else n_pass++;
`endif
    @(negedge clk); ds = 1'b1;
    @(negedge clk); ds = 1'b0; #1;
    n_checks++; if (fifo_cnt !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL stray_ds_push: fifo_cnt=%0d valid=%b required 0/0", fifo_cnt, out_valid); else n_pass++;
`ifdef RD_WAIT_TARGET_ERR_EN
    n_checks++; if (err !== 1'b1) $display("FAIL err_set: err=%b required 1", err); else n_pass++;
`endif
    fsm_read(8'h50, 4'd2, 1'b0, wsc, to);
    #1;
    n_checks++; if (wsc !== 2 || to) $display("FAIL stray_read_ws: ws_cycles=%0d required 2", wsc); else n_pass++;
`ifdef RD_WAIT_TARGET_ERR_EN
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky: err=%b required 1", err); else n_pass++;
    @(negedge clk); rst_n = 1'b0; #1;
    n_checks++; if (err !== 1'b0) $display("FAIL err_reset: err=%b required 0", err); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
`endif
    @(negedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'(i) ^ 16'hC300;
    test_reset();
    test_basic();
    test_wait_states();
    test_back_pressure();
    test_simul_push_pop();
    test_reset_mid();
    test_stray_ds();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: pending=%0d required 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rd_wait_target.md
Name: rd_wait_target

Overview:
- Read target sitting directly downstream of the read-sequencer FSM (go/rd/ds/ws protocol).
- Consumes the FSM's rd strobe and issues a single-cycle read to a synchronous memory.
- Drives the FSM's ws (wait-state) input for a programmable number of cycles, plus back-pressure.
- On the FSM's ds strobe, pushes the read word into a small output FIFO with valid/ready toward the next stage.

Parameters:
AW, 8, address width
DW, 16, data width
WCW, 4, width of wait_cfg
FIFO_DEPTH, 2, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd  in  1  read strobe from FSM
ds  in  1  done strobe from FSM
addr  in  AW  read address, sampled with accepted rd
wait_cfg  in  WCW  extra wait cycles, sampled with accepted rd
ws  out  1  wait-state to FSM
mem_en  out  1  memory read enable (1-cycle pulse)
mem_addr  out  AW  memory address
mem_rdata  in  DW  memory data, valid 1 cycle after mem_en
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream ready
out_data  out  DW  FIFO head data
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, active-low):
  - state=T_IDLE; cnt=0; data_q=0; FIFO empty.
  - ws=0, mem_en=0, mem_addr=0, out_valid=0, out_data=0, fifo_cnt=0.
- States: T_IDLE, T_WAIT, T_HOLD.
- T_IDLE:
  - ws=0.
  - rd=1 (accepted): mem_en=1 combinationally in that cycle; mem_addr=addr combinationally.
  - addr is registered into addr_q; mem_addr holds addr_q in all other cycles.
  - cnt<=wait_cfg; next=T_WAIT.
- T_WAIT:
  - First cycle after acceptance: data_q<=mem_rdata (once, via a capture flag).
  - ws = (cnt!=0) || (fifo_cnt==FIFO_DEPTH); this is a combinational decode of registered state.
  - cnt decrements each cycle while nonzero.
  - When cnt==0 and FIFO not full: ws=0, next=T_HOLD.
  - rd held high or re-asserted (FSM re-entering READ while ws=1) is treated as a continuation: no new mem_en, addr not resampled.
- T_HOLD:
  - ws=0.
  - ds=1: push data_q into FIFO; next=T_IDLE.
  - rd ignored.
- Latency, wait_cfg=0, FIFO not full:
  - rd cycle 0; ws=0 in cycle 1; T_HOLD in cycle 2.
  - The FSM's ds in cycle 2 pushes; out_valid=1 in cycle 3.
- Latency, wait_cfg=N: ws=1 for exactly N cycles starting cycle 1.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push only from T_HOLD. Space is guaranteed because T_WAIT exits only when not full and nothing else pushes.
  - Simultaneous push and pop: fifo_cnt unchanged; data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data = head entry; holds its value when out_valid=0.
- Back-pressure: FIFO full with cnt==0 → ws stays 1 until a pop frees a slot; the next cycle has ws=0.
- ds in T_IDLE or T_WAIT: ignored, no push.
- Reset mid-operation: the current transaction is dropped and the FIFO contents are discarded.

Optional Feature:
Macro: RD_WAIT_TARGET_ERR_EN
- Defined: adds output port err (1 bit, reset 0), a sticky flag cleared only by reset. err is set on any of:
  - ds while in T_IDLE or T_WAIT;
  - rd while in T_HOLD;
  - out_ready with out_valid=0 and fifo_cnt=0 for more than 0 cycles is NOT an error.
- Not defined: port absent; protocol violations are silently ignored as described above.

Test Plan:
- Basic read: mem returns 16'hA5A5 for addr 8'h10, wait_cfg=0, out_ready=1, FSM driven → single mem_en in cycle 0, ws never 1, out_valid=1 with out_data=16'hA5A5 in cycle 3.
- Wait states: wait_cfg=3, rd held during wait → ws=1 in cycles 1-3 and 0 in cycle 4, exactly one mem_en pulse, data captured from cycle 1.
- Back-pressure: out_ready=0, three back-to-back reads with data 1,2,3 → first two fill the FIFO (fifo_cnt=2), third holds ws=1. Raising out_ready pops 1; ws drops the next cycle; output order 1,2,3.
- Simultaneous push/pop: FIFO holding 1 entry, ds push coinciding with pop → fifo_cnt stays 1, correct order.
- Reset mid-operation: rst_n low during T_WAIT with wait_cfg=5 → ws=0, out_valid=0, fifo_cnt=0 immediately. After release, a fresh read completes normally.
- With RD_WAIT_TARGET_ERR_EN: ds pulse in T_IDLE → err=1 next cycle, stays 1 through later valid reads until reset.
